// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load/store size codes, exception codes
// and the LSU memory-port state encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_WORD = 2'b01,
    LS_HALF = 2'b10,
    LS_BYTE = 2'b11
  } ls_size_e;

  localparam logic [3:0] EXC_NONE = 4'd0;
  localparam logic [3:0] EXC_ADEL = 4'd4;
  localparam logic [3:0] EXC_ADES = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_EXC  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_format.sv
// Combinational lane logic: alignment check and byte-enable/store-lane
// generation for an incoming access, plus lane extract/extend for a load.
module lsu_lane_format
  import mips_pkg::*;
(
  input  ls_size_e    req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  input  ls_size_e    rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic        rsp_unsigned,
  input  logic [31:0] rsp_word,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misaligned  = 1'b0;
    be          = '0;
    wdata_lanes = '0;
    case (req_size)
      LS_WORD: begin
        misaligned  = (req_off != 2'b00);
        be          = 4'b1111;
        wdata_lanes = req_wdata;
      end
      LS_HALF: begin
        misaligned  = req_off[0];
        be          = req_off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      LS_BYTE: begin
        be          = 4'b0001 << req_off;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = rsp_word[{rsp_off, 3'b000} +: 8];
    ld_half   = rsp_off[1] ? rsp_word[31:16] : rsp_word[15:0];
    load_data = rsp_word;
    case (rsp_size)
      LS_BYTE: load_data = rsp_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      LS_HALF: load_data = rsp_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store port: accepts one access, runs a req/ack handshake
// with the data memory, and returns extended load data or an address error.
module lsu_mem_port
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        ls_bit,
  input  logic              mem_write,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              exc_valid,
  output logic [3:0]        exc_code,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  lsu_state_e        state, state_nxt;
  logic              accept;
  logic              misaligned;
  logic [3:0]        be_fmt;
  logic [31:0]       wdata_fmt;
  logic [31:0]       load_data;

  ls_size_e          size_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic              uns_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  assign accept = (state == ST_IDLE) && req_valid && (ls_bit != LS_NONE);

  // Store lanes and enables are formatted from the live inputs at accept and
  // latched, so the memory side never sees upstream changes while BUSY.
  lsu_lane_format u_lane_format (
    .req_size     (ls_size_e'(ls_bit)),
    .req_off      (addr[1:0]),
    .req_wdata    (wdata),
    .misaligned   (misaligned),
    .be           (be_fmt),
    .wdata_lanes  (wdata_fmt),
    .rsp_size     (size_q),
    .rsp_off      (off_q),
    .rsp_unsigned (uns_q),
    .rsp_word     (dm_rdata),
    .load_data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = misaligned ? ST_EXC : ST_BUSY;
      ST_BUSY: if (dm_ack) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      ST_EXC:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q      <= LS_NONE;
      off_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      word_addr_q <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        size_q      <= ls_size_e'(ls_bit);
        off_q       <= addr[1:0];
        we_q        <= mem_write;
        uns_q       <= load_unsigned;
        word_addr_q <= {addr[ADDR_W-1:2], 2'b00};
        be_q        <= be_fmt;
        wdata_q     <= wdata_fmt;
      end
      if (state == ST_BUSY && dm_ack && !we_q) rdata_q <= load_data;
    end
  end

  always_comb begin
    stall       = (state == ST_BUSY) || accept;
    done        = (state == ST_RESP);
    rdata_valid = done && !we_q;
    exc_valid   = (state == ST_EXC);
    exc_code    = exc_valid ? (we_q ? EXC_ADES : EXC_ADEL) : EXC_NONE;
    dm_req      = (state == ST_BUSY);
    dm_we       = dm_req && we_q;
    dm_be       = dm_req ? be_q : '0;
    dm_addr     = dm_req ? word_addr_q : '0;
    dm_wdata    = dm_req ? wdata_q : '0;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases plus randomized
// accesses compared every cycle against a transaction-level model.
module tb_lsu_mem_port;

  localparam logic [1:0] SZ_N = 2'b00, SZ_W = 2'b01, SZ_H = 2'b10, SZ_B = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_write, load_unsigned;
  logic [1:0]  ls_bit;
  logic [31:0] addr, wdata;
  logic        stall, done, rdata_valid, exc_valid;
  logic [31:0] rdata;
  logic [3:0]  exc_code;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;

  int checks = 0;
  int errors = 0;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .ls_bit(ls_bit),
    .mem_write(mem_write), .load_unsigned(load_unsigned), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc_valid(exc_valid), .exc_code(exc_code),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, set by the stimulus process.
  logic        e_stall, e_done, e_rvalid, e_exc, e_req, e_we;
  logic [3:0]  e_code, e_be;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] e_rdata = '0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",       32'(stall),       32'(e_stall));
      chk("done",        32'(done),        32'(e_done));
      chk("rdata_valid", 32'(rdata_valid), 32'(e_rvalid));
      chk("rdata",       rdata,            e_rdata);
      chk("exc_valid",   32'(exc_valid),   32'(e_exc));
      chk("exc_code",    32'(exc_code),    32'(e_code));
      chk("dm_req",      32'(dm_req),      32'(e_req));
      chk("dm_we",       32'(dm_we),       32'(e_we));
      chk("dm_be",       32'(dm_be),       32'(e_be));
      chk("dm_addr",     dm_addr,          e_addr);
      chk("dm_wdata",    dm_wdata,         e_wdata);
    end
  end

  // ---- reference model ----
  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      SZ_W:    return 4;
      SZ_H:    return 2;
      SZ_B:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (n > 0) && ((a % n) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [7:0] t;
    t = 8'((1 << nbytes(sz)) - 1) << (a % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] word);
    logic [31:0] v, mask;
    int n = nbytes(sz);
    if (n == 4) return word;
    v    = word >> (8 * (a % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    e_stall = 0; e_done = 0; e_rvalid = 0; e_exc = 0; e_code = '0;
    e_req = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic scramble();
    req_valid     = 1'($urandom);
    ls_bit        = 2'($urandom);
    mem_write     = 1'($urandom);
    load_unsigned = 1'($urandom);
    addr          = $urandom;
    wdata         = $urandom;
  endtask

  task automatic do_access(input logic [1:0] sz, input logic we, input logic uns,
                           input logic [31:0] a, input logic [31:0] w,
                           input int delay, input logic [31:0] rword);
    req_valid = 1; ls_bit = sz; mem_write = we; load_unsigned = uns; addr = a; wdata = w;
    dm_ack = 1'($urandom); dm_rdata = $urandom;
    idle_exp(); e_stall = 1;
    tick();
    scramble();
    if (m_misaligned(sz, a)) begin
      idle_exp(); e_exc = 1; e_code = we ? 4'd5 : 4'd4;
      tick();
      req_valid = 0; dm_ack = 0; idle_exp();
      return;
    end
    for (int d = 0; d <= delay; d++) begin
      idle_exp();
      e_stall = 1; e_req = 1; e_we = we; e_be = m_be(sz, a);
      e_addr = a & 32'hFFFF_FFFC; e_wdata = m_wdata(sz, w);
      dm_ack   = (d == delay);
      dm_rdata = (d == delay) ? rword : $urandom;
      if (d > 0) scramble();
      tick();
    end
    idle_exp(); e_done = 1; e_rvalid = !we;
    if (!we) e_rdata = m_load(sz, a, uns, rword);
    dm_ack = 1'($urandom); dm_rdata = $urandom; req_valid = 1'($urandom);
    tick();
    req_valid = 0; dm_ack = 0; idle_exp();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'($urandom); ls_bit = SZ_N; addr = $urandom;
      dm_ack = 1'($urandom); dm_rdata = $urandom;
      idle_exp();
      tick();
    end
    req_valid = 0; dm_ack = 0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1; req_valid = 0; ls_bit = SZ_N; mem_write = 0; load_unsigned = 0;
    addr = '0; wdata = '0; dm_rdata = '0; dm_ack = 0;
    idle_exp();
    chk_en = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    tick();

    // Pin the model with hand-computed values.
    chk("model_lb",    m_load(SZ_B, 32'h203, 1'b0, 32'h80112233), 32'hFFFFFF80);
    chk("model_lbu",   m_load(SZ_B, 32'h203, 1'b1, 32'h80112233), 32'h00000080);
    chk("model_lhu",   m_load(SZ_H, 32'h6,   1'b1, 32'hFFEE0000), 32'h0000FFEE);
    chk("model_sh_be", 32'(m_be(SZ_H, 32'h42)),                   32'h0000000C);
    chk("model_sh_wd", m_wdata(SZ_H, 32'h1234ABCD),               32'hABCDABCD);
    chk("model_lb_be", 32'(m_be(SZ_B, 32'h203)),                  32'h00000008);

    // Directed cases.
    do_access(SZ_W, 0, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    do_access(SZ_B, 0, 0, 32'h203, 32'h0, 0, 32'h80112233);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    do_access(SZ_B, 0, 1, 32'h203, 32'h0, 1, 32'h80112233);
    chk("lbu_rdata", rdata, 32'h00000080);
    do_access(SZ_H, 1, 0, 32'h42, 32'h1234ABCD, 0, 32'h0);
    chk("sh_keeps_rdata", rdata, 32'h00000080);
    do_access(SZ_W, 0, 0, 32'h102, 32'h0, 0, 32'h0);
    do_access(SZ_H, 1, 0, 32'h41, 32'h5555, 0, 32'h0);
    chk("exc_keeps_rdata", rdata, 32'h00000080);
    do_access(SZ_W, 0, 0, 32'h300, 32'h0, 5, 32'hCAFEF00D);
    idle_cycles(3);

    // Reset while BUSY abandons the access.
    req_valid = 1; ls_bit = SZ_W; mem_write = 0; addr = 32'h400;
    idle_exp(); e_stall = 1;
    tick();
    req_valid = 0; dm_ack = 0;
    idle_exp(); e_stall = 1; e_req = 1; e_be = 4'hF; e_addr = 32'h400;
    e_wdata = m_wdata(SZ_W, wdata);
    tick();
    rst = 1; dm_ack = 1; dm_rdata = 32'h11111111;
    idle_exp(); e_rdata = '0;
    tick();
    rst = 0; dm_ack = 0;
    tick();
    do_access(SZ_H, 0, 1, 32'h6, 32'h0, 0, 32'hFFEE0000);
    chk("lhu_rdata", rdata, 32'h0000FFEE);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(1, 3));
      a  = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      do_access(sz, 1'($urandom), 1'($urandom), a, $urandom,
                $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
